// File: rtl/execute_muldiv_if.sv
// Request/result bundle between the issue stage and the iterative multiply/divide unit.
// The issue side drives the master modport; the execute unit uses slave.
interface execute_muldiv_if #(
  parameter int XLEN  = 32,
  parameter int XADDR = 5
);
  logic             i_valid;
  logic [2:0]       i_funct3;
  logic [XLEN-1:0]  i_rs1_data;
  logic [XLEN-1:0]  i_rs2_data;
  logic [XADDR-1:0] i_rd_addr;
  logic             i_flush;
  logic             i_stall;
  logic             o_ready;
  logic             or_stall;
  logic             or_valid;
  logic [XLEN-1:0]  or_result;
  logic [XADDR-1:0] or_rd_addr;

  modport master (
    output i_valid, i_funct3, i_rs1_data, i_rs2_data, i_rd_addr, i_flush, i_stall,
    input  o_ready, or_stall, or_valid, or_result, or_rd_addr
  );

  modport slave (
    input  i_valid, i_funct3, i_rs1_data, i_rs2_data, i_rd_addr, i_flush, i_stall,
    output o_ready, or_stall, or_valid, or_result, or_rd_addr
  );
endinterface

// File: rtl/execute_muldiv.sv
// Iterative RV32M-style multiply/divide: one shift-add or restoring-divide step per BUSY cycle
// on operand magnitudes, with the sign fixed up on the final iteration.
module execute_muldiv #(
  parameter int XLEN  = 32,
  parameter int XADDR = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  execute_muldiv_if.slave  bus
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [2*XLEN-1:0]   r_acc, w_acc_nxt;
  logic [XLEN-1:0]     r_opb;
  logic [2:0]          r_funct3;
  logic [XADDR-1:0]    r_rd;
  logic                r_neg;

  logic                w_accept, w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic                w_div0, w_ovf, w_special, w_neg;
  logic [XLEN-1:0]     w_mag_a, w_mag_b, w_special_res;
  logic [XLEN:0]       w_sum, w_trial;
  logic [2*XLEN-1:0]   w_prod_fin;
  logic [XLEN-1:0]     w_quo, w_rem, w_iter_res;
  logic                w_valid_nxt, w_stall_nxt;

  function automatic logic [XLEN-1:0] f_mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
  endfunction

  function automatic logic [XLEN-1:0] f_cneg(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + XLEN'(1)) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] f_cneg2(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (~v + (2*XLEN)'(1)) : v;
  endfunction

  // Request decode: signedness, magnitudes and the two single-cycle divide cases
  always_comb begin
    w_accept  = (r_state == S_IDLE) && bus.i_valid && !bus.i_flush;
    w_is_div  = bus.i_funct3[2];
    w_a_sgn   = (bus.i_funct3 == 3'b001) || (bus.i_funct3 == 3'b010) ||
                (bus.i_funct3 == 3'b100) || (bus.i_funct3 == 3'b110);
    w_b_sgn   = (bus.i_funct3 == 3'b001) || (bus.i_funct3 == 3'b100) ||
                (bus.i_funct3 == 3'b110);
    w_a_neg   = w_a_sgn && bus.i_rs1_data[XLEN-1];
    w_b_neg   = w_b_sgn && bus.i_rs2_data[XLEN-1];
    w_mag_a   = f_mag(bus.i_rs1_data, w_a_sgn);
    w_mag_b   = f_mag(bus.i_rs2_data, w_b_sgn);
    // Remainder sign follows the dividend only; everything else is the XOR of the signs.
    w_neg     = w_a_neg ^ (w_b_neg && (bus.i_funct3 != 3'b110));
    w_div0    = w_is_div && (bus.i_rs2_data == '0);
    w_ovf     = w_is_div && !bus.i_funct3[0] &&
                (bus.i_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (bus.i_rs2_data == '1);
    w_special = w_div0 || w_ovf;
    if (bus.i_funct3[1]) w_special_res = w_div0 ? bus.i_rs1_data : '0;
    else                 w_special_res = w_div0 ? '1 : bus.i_rs1_data;
  end

  always_comb begin
    w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    w_trial = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]} - {1'b0, r_opb};
    if (r_funct3[2]) begin
      if (!w_trial[XLEN]) w_acc_nxt = {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      else                w_acc_nxt = {r_acc[2*XLEN-2:0], 1'b0};
    end else begin
      w_acc_nxt = {w_sum, r_acc[XLEN-1:1]};
    end
    w_prod_fin = f_cneg2(w_acc_nxt, r_neg);
    w_quo      = f_cneg(w_acc_nxt[XLEN-1:0], r_neg);
    w_rem      = f_cneg(w_acc_nxt[2*XLEN-1:XLEN], r_neg);
    if (r_funct3[2])               w_iter_res = r_funct3[1] ? w_rem : w_quo;
    else if (r_funct3[1:0] == 2'b00) w_iter_res = w_prod_fin[XLEN-1:0];
    else                           w_iter_res = w_prod_fin[2*XLEN-1:XLEN];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.i_flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.i_valid) w_state_nxt = w_special ? S_DONE : S_BUSY;
        S_BUSY:  if (r_cnt == CW'(XLEN-1)) w_state_nxt = S_DONE;
        S_DONE:  if (!bus.i_stall) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.o_ready = (r_state == S_IDLE);
    w_valid_nxt = (w_state_nxt == S_DONE);
    w_stall_nxt = (w_state_nxt == S_BUSY) || ((w_state_nxt == S_DONE) && bus.i_stall);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bus.or_valid   <= 1'b0;
      bus.or_stall   <= 1'b0;
      bus.or_result  <= '0;
      bus.or_rd_addr <= '0;
      r_cnt          <= '0;
    end else begin
      bus.or_valid <= w_valid_nxt;
      bus.or_stall <= w_stall_nxt;
      if (w_accept)                r_cnt <= '0;
      else if (r_state == S_BUSY)  r_cnt <= r_cnt + CW'(1);
      // Result bundle is written only on entry to DONE so it holds for the whole DONE interval
      if (r_state == S_IDLE && w_state_nxt == S_DONE) begin
        bus.or_result  <= w_special_res;
        bus.or_rd_addr <= bus.i_rd_addr;
      end else if (r_state == S_BUSY && w_state_nxt == S_DONE) begin
        bus.or_result  <= w_iter_res;
        bus.or_rd_addr <= r_rd;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_funct3 <= bus.i_funct3;
      r_rd     <= bus.i_rd_addr;
      r_neg    <= w_neg;
      r_acc    <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
      r_opb    <= w_is_div ? w_mag_b : w_mag_a;
    end else if (r_state == S_BUSY) begin
      r_acc    <= w_acc_nxt;
    end
  end
endmodule
